// File: rtl/sram_ctrl.sv
// Sequences 32-bit MEM-stage loads/stores onto an external 16-bit asynchronous SRAM
// as two half-word accesses (low half first), each lasting WAIT_CYCLES clocks.
module sram_ctrl #(
    parameter int WAIT_CYCLES = 5,
    parameter int ADDR_BASE   = 1024,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    input  logic [31:0]        ALU_res,
    input  logic [31:0]        val_rm,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n,
    output logic [1:0]         dbg_state
);

    localparam int       WAW      = SRAM_AW - 1;
    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    // Handshake: ready=1 means the MEM stage may advance this cycle. A request
    // (MEM_R_EN|MEM_W_EN) seen in IDLE is accepted on that edge; the pipeline must
    // hold its inputs stable until ready returns high in DONE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [WAW-1:0]     wa_q, wa_d;
    logic [31:0]        wd_q, wd_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;
    logic [15:0]        dq_q, dq_d;
    logic               oe_q, oe_d;
    logic               we_n_q, we_n_d;

    logic               req;
    logic [31:0]        byte_off;
    logic [WAW-1:0]     req_wa;

    assign req      = MEM_R_EN | MEM_W_EN;
    assign byte_off = ALU_res - 32'(ADDR_BASE);
    assign req_wa   = WAW'(byte_off >> 2);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        wa_d    = wa_q;
        wd_d    = wd_q;
        rdata_d = rdata_q;
        ready   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = ~req;
                if (req) begin
                    state_d = ST_LO;
                    cnt_d   = 4'd0;
                    wr_d    = MEM_W_EN;
                    wa_d    = req_wa;
                    wd_d    = val_rm;
                end
            end
            ST_LO: begin
                if (cnt_q == CNT_LAST) begin
                    if (!wr_q) rdata_d[15:0] = sram_dq_in;
                    state_d = ST_HI;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_HI: begin
                if (cnt_q == CNT_LAST) begin
                    if (!wr_q) rdata_d[31:16] = sram_dq_in;
                    state_d = ST_DONE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                ready   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pin registers are loaded from the next state so they line up with it;
    // we_n rises one cycle before the half ends, keeping address/data stable across it.
    always_comb begin
        addr_d = addr_q;
        dq_d   = dq_q;
        oe_d   = 1'b0;
        we_n_d = 1'b1;
        if (state_d == ST_LO || state_d == ST_HI) begin
            addr_d = {wa_d, (state_d == ST_HI)};
            dq_d   = (state_d == ST_HI) ? wd_d[31:16] : wd_d[15:0];
            oe_d   = wr_d;
            we_n_d = !(wr_d && (cnt_d != CNT_LAST));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= 32'd0;
            rdata_q <= 32'd0;
            addr_q  <= '0;
            dq_q    <= 16'd0;
            oe_q    <= 1'b0;
            we_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            dq_q    <= dq_d;
            oe_q    <= oe_d;
            we_n_q  <= we_n_d;
        end
    end

    assign rdata       = rdata_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_q;
    assign sram_dq_oe  = oe_q;
    assign sram_we_n   = we_n_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed and randomised load/store sequences against a behavioural async SRAM,
// with a queue of expected load data checked in each DONE cycle.
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MEM_R_EN = 1'b0;
    logic        MEM_W_EN = 1'b0;
    logic [31:0] ALU_res = 32'd0;
    logic [31:0] val_rm = 32'd0;
    logic [31:0] rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] shadow[logic [31:0]];
    logic [31:0] last_rd = 32'd0;
    logic [15:0] mem [0:(1<<18)-1];

    sram_ctrl #(.WAIT_CYCLES(5), .ADDR_BASE(1024), .SRAM_AW(18)) dut (
        .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .ALU_res(ALU_res), .val_rm(val_rm), .rdata(rdata), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: latches on the rising edge of we_n, reads asynchronously.
    always @(posedge sram_we_n) begin
        if (!rst && sram_dq_oe) mem[sram_addr] = sram_dq_out;
    end
    assign sram_dq_in = mem[sram_addr];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full access; caller is just after a rising edge. chg swaps ALU_res mid-LO.
    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic chg, input logic [31:0] a2);
        logic [31:0] wa;
        logic [17:0] exp_lo, exp_hi;
        int lows, we_l, we_h;
        logic done, addr_ok;
        wa     = (a - 32'd1024) >> 2;
        exp_lo = {wa[16:0], 1'b0};
        exp_hi = {wa[16:0], 1'b1};
        lows = 0; we_l = 0; we_h = 0; done = 1'b0; addr_ok = 1'b1;
        MEM_R_EN = r; MEM_W_EN = w; ALU_res = a; val_rm = d;
        if (w) shadow[wa] = d;
        else if (r) exp_q.push_back(shadow.exists(wa) ? shadow[wa] : 32'd0);
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (ready) begin
                done = 1'b1;
            end else begin
                lows++;
                if (chg && lows == 3) ALU_res = a2;
                if (lows >= 2 && lows <= 6 && sram_addr !== exp_lo) addr_ok = 1'b0;
                if (lows >= 7 && sram_addr !== exp_hi) addr_ok = 1'b0;
                if (!sram_we_n) begin
                    if (sram_addr[0]) we_h++;
                    else we_l++;
                end
            end
        end
        check("ready_low_len", 32'(lows), 32'd11);
        check("addr_stable", {31'd0, addr_ok}, 32'd1);
        check("done_state", {30'd0, dbg_state}, 32'd3);
        if (w) begin
            check("we_lo_cycles", 32'(we_l), 32'd4);
            check("we_hi_cycles", 32'(we_h), 32'd4);
            check("mem_lo", {16'd0, mem[exp_lo]}, {16'd0, d[15:0]});
            check("mem_hi", {16'd0, mem[exp_hi]}, {16'd0, d[31:16]});
            check("rdata_kept", rdata, last_rd);
        end else begin
            check("we_read", 32'(we_l + we_h), 32'd0);
            if (exp_q.size() > 0) begin
                last_rd = exp_q.pop_front();
                check("rdata_done", rdata, last_rd);
            end
        end
        @(posedge clk); #1;
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    endtask

    initial begin
        logic [31:0] ra, rd;
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        check("rst_oe", {31'd0, sram_dq_oe}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_state", {30'd0, dbg_state}, 32'd0);
        check("idle_ready", {31'd0, ready}, 32'd1);
        check("idle_rdata", rdata, 32'd0);

        // Reset during the high half of a write
        @(posedge clk); #1;
        MEM_W_EN = 1'b1; ALU_res = 32'd1040; val_rm = 32'h1111_2222;
        repeat (8) @(negedge clk);
        check("mid_hi_state", {30'd0, dbg_state}, 32'd2);
        check("mid_hi_we_n", {31'd0, sram_we_n}, 32'd0);
        check("mid_hi_oe", {31'd0, sram_dq_oe}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("async_we_n", {31'd0, sram_we_n}, 32'd1);
        check("async_oe", {31'd0, sram_dq_oe}, 32'd0);
        MEM_W_EN = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_state", {30'd0, dbg_state}, 32'd0);
        check("post_rst_ready", {31'd0, ready}, 32'd1);
        check("post_rst_rdata", rdata, 32'd0);

        // Write then read back
        @(posedge clk); #1;
        access(1'b0, 1'b1, 32'd1028, 32'hDEAD_BEEF, 1'b0, 32'd0);
        check("loc2", {16'd0, mem[2]}, 32'h0000_BEEF);
        check("loc3", {16'd0, mem[3]}, 32'h0000_DEAD);
        access(1'b1, 1'b0, 32'd1028, 32'd0, 1'b0, 32'd0);
        repeat (3) @(negedge clk);
        check("rdata_held", rdata, 32'hDEAD_BEEF);

        // Back-to-back load then store
        @(posedge clk); #1;
        access(1'b1, 1'b0, 32'd1028, 32'd0, 1'b0, 32'd0);
        access(1'b0, 1'b1, 32'd1032, 32'h1234_5678, 1'b0, 32'd0);

        // Both enables set, address changed mid-LO
        access(1'b1, 1'b1, 32'd1036, 32'hCAFE_F00D, 1'b1, 32'd1200);
        check("both_rdata", rdata, 32'hDEAD_BEEF);
        check("chg_addr_untouched", {16'd0, mem[88]}, 32'd0);

        // Address wrap below ADDR_BASE
        access(1'b0, 1'b1, 32'd1020, 32'hA5A5_5A5A, 1'b0, 32'd0);
        check("wrap_lo", {16'd0, mem[18'h3FFFE]}, 32'h0000_5A5A);
        check("wrap_hi", {16'd0, mem[18'h3FFFF]}, 32'h0000_A5A5);
        access(1'b1, 1'b0, 32'd1020, 32'd0, 1'b0, 32'd0);
        access(1'b1, 1'b0, 32'd1032, 32'd0, 1'b0, 32'd0);

        // Random store/load pairs
        for (int i = 0; i < 4; i++) begin
            ra = 32'd1024 + 32'd4 * 32'($urandom_range(16, 500));
            rd = $urandom;
            access(1'b0, 1'b1, ra, rd, 1'b0, 32'd0);
            access(1'b1, 1'b0, ra, 32'd0, 1'b0, 32'd0);
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
